// File: rtl/alu_stage_pkg.sv
// +------------------------------------------------------------------+
// | alu_stage_pkg: shared types and constants for the ALU result     |
// | stage (branch condition codes, ALU flag layout).                 |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package alu_stage_pkg;

  typedef enum logic [2:0] {
    BR_NONE   = 3'd0,
    BR_EQ     = 3'd1,
    BR_NE     = 3'd2,
    BR_LT     = 3'd3,
    BR_GE     = 3'd4,
    BR_GT     = 3'd5,
    BR_LE     = 3'd6,
    BR_ALWAYS = 3'd7
  } br_op_t;

  typedef struct packed {
    logic overflow;
    logic negative;
    logic zero;
    logic equal;
    logic greater;
    logic less;
  } alu_flags_t;

  localparam int c_flags_w     = 6;
  localparam int c_flag_less   = 0;
  localparam int c_flag_gt     = 1;
  localparam int c_flag_eq     = 2;
  localparam int c_flag_zero   = 3;
  localparam int c_flag_neg    = 4;
  localparam int c_flag_ovf    = 5;

endpackage

`default_nettype wire

// File: rtl/branch_eval.sv
// +------------------------------------------------------------------+
// | branch_eval: combinational branch decision from a condition code |
// | and the ALU compare flags.                                       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module branch_eval
  import alu_stage_pkg::*;
(
  input  br_op_t     br_op,
  input  alu_flags_t flags,
  output logic       taken
);

  logic [c_flags_w-1:0] w_f;
  logic                 w_unused_flags;

  assign w_f            = flags;
  // Only the compare flags take part in the decision.
  assign w_unused_flags = ^{w_f[c_flag_ovf], w_f[c_flag_neg], w_f[c_flag_zero]};

  always_comb begin
    taken = 1'b0;
    case (br_op)
      BR_NONE:   taken = 1'b0;
      BR_EQ:     taken = w_f[c_flag_eq];
      BR_NE:     taken = ~w_f[c_flag_eq];
      BR_LT:     taken = w_f[c_flag_less];
      BR_GE:     taken = ~w_f[c_flag_less];
      BR_GT:     taken = w_f[c_flag_gt];
      BR_LE:     taken = ~w_f[c_flag_gt];
      BR_ALWAYS: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_result_stage.sv
// +------------------------------------------------------------------+
// | alu_result_stage: FIFO skid buffer after the ALU with per-entry  |
// | branch decision. Optional macro: ALU_STAGE_OVF_TRAP_EN.          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module alu_result_stage
  import alu_stage_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int RD_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_result,
  input  logic [c_flags_w-1:0] in_flags,
  input  logic [2:0]           in_br_op,
  input  logic [RD_W-1:0]      in_rd,
  input  logic                 in_wb_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_result,
  output logic [c_flags_w-1:0] out_flags,
  output logic [RD_W-1:0]      out_rd,
  output logic                 out_wb_en,
  output logic                 out_br_taken,
  output logic                 ovf_trap,
  input  logic                 ovf_clear
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_cnt_w  = c_addr_w + 1;

  logic [c_cnt_w-1:0]   r_count;
  logic [c_addr_w-1:0]  r_wr_ptr;
  logic [c_addr_w-1:0]  r_rd_ptr;

  logic [DATA_W-1:0]    r_result  [DEPTH];
  logic [c_flags_w-1:0] r_flags   [DEPTH];
  logic [RD_W-1:0]      r_rd      [DEPTH];
  logic                 r_wb_en   [DEPTH];
  logic                 r_br      [DEPTH];

  logic w_push;
  logic w_pop;
  logic w_valid;
  logic w_taken;
  logic w_wb_en_store;

  assign w_valid  = (r_count != '0);
  assign in_ready = (r_count < c_cnt_w'(DEPTH));
  assign w_push   = in_valid & in_ready;
  assign w_pop    = w_valid & out_ready;

  branch_eval u_branch_eval (
    .br_op (br_op_t'(in_br_op)),
    .flags (alu_flags_t'(in_flags)),
    .taken (w_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A write during flush is harmless: the write pointer does not advance.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_result[r_wr_ptr] <= in_result;
      r_flags[r_wr_ptr]  <= in_flags;
      r_rd[r_wr_ptr]     <= in_rd;
      r_wb_en[r_wr_ptr]  <= w_wb_en_store;
      r_br[r_wr_ptr]     <= w_taken;
    end
  end

  assign out_valid    = w_valid;
  assign out_result   = w_valid ? r_result[r_rd_ptr] : '0;
  assign out_flags    = w_valid ? r_flags[r_rd_ptr]  : '0;
  assign out_rd       = w_valid ? r_rd[r_rd_ptr]     : '0;
  assign out_wb_en    = w_valid & r_wb_en[r_rd_ptr];
  assign out_br_taken = w_valid & r_br[r_rd_ptr];

`ifdef ALU_STAGE_OVF_TRAP_EN
  logic r_ovf_trap;
  logic w_ovf_set;

  assign w_ovf_set     = w_push & in_flags[c_flag_ovf] & in_wb_en;
  assign w_wb_en_store = in_wb_en & ~in_flags[c_flag_ovf];
  assign ovf_trap      = r_ovf_trap;

  // Clear takes priority over a set in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_trap <= 1'b0;
    end else if (ovf_clear) begin
      r_ovf_trap <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf_trap <= 1'b1;
    end
  end
`else
  logic w_unused_ovf_clear;

  assign w_unused_ovf_clear = ovf_clear;
  assign w_wb_en_store      = in_wb_en;
  assign ovf_trap           = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// +------------------------------------------------------------------+
// | tb_alu_result_stage: directed + random checks of the ALU result  |
// | stage against a queue-based reference model.                     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_alu_result_stage;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 2;
  localparam int RD_W   = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_result = '0;
  logic [5:0]        in_flags = '0;
  logic [2:0]        in_br_op = '0;
  logic [RD_W-1:0]   in_rd = '0;
  logic              in_wb_en = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_result;
  logic [5:0]        out_flags;
  logic [RD_W-1:0]   out_rd;
  logic              out_wb_en;
  logic              out_br_taken;
  logic              ovf_trap;
  logic              ovf_clear = 1'b0;

  alu_result_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .in_br_op     (in_br_op),
    .in_rd        (in_rd),
    .in_wb_en     (in_wb_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_rd       (out_rd),
    .out_wb_en    (out_wb_en),
    .out_br_taken (out_br_taken),
    .ovf_trap     (ovf_trap),
    .ovf_clear    (ovf_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] res;
    logic [5:0]        fl;
    logic [RD_W-1:0]   rd;
    logic              wb;
    logic              br;
  } ent_t;

  ent_t q[$];
  logic ref_trap = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Flag order {ovf, neg, zero, equal, greater, less}.
  function automatic logic ref_branch(input logic [2:0] op, input logic [5:0] f);
    case (op)
      3'd0:    return 1'b0;
      3'd1:    return f[2];
      3'd2:    return !f[2];
      3'd3:    return f[0];
      3'd4:    return !f[0];
      3'd5:    return f[1];
      3'd6:    return !f[1];
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("ovf_trap", 64'(ovf_trap), 64'(ref_trap));
    if (q.size() > 0) begin
      chk("out_result", out_result, q[0].res);
      chk("out_flags", 64'(out_flags), 64'(q[0].fl));
      chk("out_rd", 64'(out_rd), 64'(q[0].rd));
      chk("out_wb_en", 64'(out_wb_en), 64'(q[0].wb));
      chk("out_br_taken", 64'(out_br_taken), 64'(q[0].br));
    end else begin
      chk("out_wb_en_idle", 64'(out_wb_en), 64'd0);
      chk("out_br_taken_idle", 64'(out_br_taken), 64'd0);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] res, input logic [5:0] fl,
                       input logic [2:0] op, input logic [4:0] rd, input logic wb);
    in_valid  = v;
    in_result = res;
    in_flags  = fl;
    in_br_op  = op;
    in_rd     = rd;
    in_wb_en  = wb;
  endtask

  // Advance one clock, update the model from the inputs presented, then check.
  task automatic step();
    logic push, pop;
    ent_t e;
    push = in_valid && (q.size() < DEPTH);
    pop  = (q.size() > 0) && out_ready;
    @(posedge clk);
`ifdef ALU_STAGE_OVF_TRAP_EN
    if (ovf_clear) ref_trap = 1'b0;
    else if (push && in_flags[5] && in_wb_en) ref_trap = 1'b1;
`endif
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.res = in_result;
        e.fl  = in_flags;
        e.rd  = in_rd;
`ifdef ALU_STAGE_OVF_TRAP_EN
        e.wb  = in_wb_en && !in_flags[5];
`else
        e.wb  = in_wb_en;
`endif
        e.br  = ref_branch(in_br_op, in_flags);
        q.push_back(e);
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_ovf_trap", 64'(ovf_trap), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    #10 rst_n = 1'b1;

    // Streaming, one entry per cycle with no bubbles.
    out_ready = 1'b1;
    drive(1, 64'h1, 6'd0, 3'd0, 5'd1, 1); step(); chk("stream_1", out_result, 64'h1);
    drive(1, 64'h2, 6'd0, 3'd0, 5'd2, 1); step(); chk("stream_2", out_result, 64'h2);
    drive(1, 64'h3, 6'd0, 3'd0, 5'd3, 1); step(); chk("stream_3", out_result, 64'h3);
    drive(0, 64'h0, 6'd0, 3'd0, 5'd0, 0); step(); chk("stream_done", 64'(out_valid), 64'd0);

    // Backpressure: third push blocked, then drain in order.
    out_ready = 1'b0;
    drive(1, 64'hA, 6'd0, 3'd0, 5'd4, 1); step();
    drive(1, 64'hB, 6'd0, 3'd0, 5'd5, 1); step(); chk("bp_full", 64'(in_ready), 64'd0);
    drive(1, 64'hC, 6'd0, 3'd0, 5'd6, 1); step(); chk("bp_head", out_result, 64'hA);
    out_ready = 1'b1;
    drive(0, 64'h0, 6'd0, 3'd0, 5'd0, 0); step(); chk("bp_drain_b", out_result, 64'hB);
    step(); chk("bp_ready_back", 64'(in_ready), 64'd1);

    // Branch decisions.
    drive(1, 64'h10, 6'b000001, 3'd3, 5'd1, 0); step(); chk("br_lt", 64'(out_br_taken), 64'd1);
    drive(1, 64'h11, 6'b000001, 3'd4, 5'd1, 0); step(); chk("br_ge", 64'(out_br_taken), 64'd0);
    drive(1, 64'h12, 6'b000100, 3'd2, 5'd1, 0); step(); chk("br_ne", 64'(out_br_taken), 64'd0);
    drive(1, 64'h13, 6'b000000, 3'd7, 5'd1, 0); step(); chk("br_always", 64'(out_br_taken), 64'd1);
    drive(0, 64'h0, 6'd0, 3'd0, 5'd0, 0); step();

    // Asynchronous reset with two entries buffered.
    out_ready = 1'b0;
    drive(1, 64'h20, 6'b100000, 3'd0, 5'd7, 1); step();
    drive(1, 64'h21, 6'd0, 3'd0, 5'd8, 1); step();
    drive(0, 64'h0, 6'd0, 3'd0, 5'd0, 0);
    #3 rst_n = 1'b0;
    #1;
    q.delete();
    ref_trap = 1'b0;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_ovf_trap", 64'(ovf_trap), 64'd0);
    #2 rst_n = 1'b1;
    step();

    // Flush with a simultaneous push at count=1.
    drive(1, 64'h30, 6'd0, 3'd0, 5'd9, 1); step();
    flush = 1'b1;
    drive(1, 64'h31, 6'd0, 3'd0, 5'd10, 1); step(); chk("flush_empty", 64'(out_valid), 64'd0);
    flush = 1'b0;
    drive(0, 64'h0, 6'd0, 3'd0, 5'd0, 0); step(); chk("flush_lost", 64'(out_valid), 64'd0);

    // Overflow handling.
    drive(1, 64'h40, 6'b100000, 3'd0, 5'd11, 1); step();
`ifdef ALU_STAGE_OVF_TRAP_EN
    chk("ovf_set", 64'(ovf_trap), 64'd1);
    chk("ovf_wb_sup", 64'(out_wb_en), 64'd0);
`else
    chk("ovf_tied", 64'(ovf_trap), 64'd0);
    chk("ovf_wb_kept", 64'(out_wb_en), 64'd1);
`endif
    out_ready = 1'b1;
    ovf_clear = 1'b1;
    drive(1, 64'h41, 6'b100000, 3'd0, 5'd12, 1); step(); chk("ovf_clear_wins", 64'(ovf_trap), 64'd0);
    ovf_clear = 1'b0;
    drive(0, 64'h0, 6'd0, 3'd0, 5'd0, 0); step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, {$urandom, $urandom}, 6'($urandom),
            3'($urandom), 5'($urandom), 1'($urandom));
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 20) == 0;
      ovf_clear = ($urandom % 10) == 0;
      step();
    end
    flush = 1'b0;
    ovf_clear = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered stage directly downstream of the 64-bit ALU.
- Captures the ALU result, status flags and destination info into a small FIFO skid buffer with valid/ready handshakes.
- Evaluates the branch condition from the captured compare flags.
- Presents one entry per cycle to the write-back/PC-select logic and decouples ALU timing from write-back stalls.

Parameters:
- DATA_W, 64, width of result datapath (matches ALU).
- DEPTH, 2, buffer entries; power of two, ≥2.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all buffered entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  buffer can accept (registered, = count < DEPTH).
- in_result  input  DATA_W  ALU result.
- in_flags  input  6  {overflow, negative, zero, equal, greater, less} from ALU.
- in_br_op  input  3  branch condition code (br_op_t).
- in_rd  input  RD_W  destination register.
- in_wb_en  input  1  register write enable.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts.
- out_result  output  DATA_W  head result.
- out_flags  output  6  head flags.
- out_rd  output  RD_W  head destination.
- out_wb_en  output  1  head write enable; forced 0 when out_valid=0.
- out_br_taken  output  1  head branch decision; forced 0 when out_valid=0.
- ovf_trap  output  1  sticky overflow trap (see Optional Feature).
- ovf_clear  input  1  clears ovf_trap.

Behaviour:
- Reset (rst_n=0, async): count=0, rd/wr pointers=0, out_valid=0, in_ready=1, out_* data=0, ovf_trap=0. Storage contents need not be cleared.
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Both may occur in the same cycle.
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1. Throughput is 1 entry/cycle with out_ready held high.
- Counter: count' = count + push − pop. Pointers wrap modulo DEPTH.
- Full (count=DEPTH): in_ready=0, in_valid ignored. A pop that cycle frees a slot for the next cycle only; no same-cycle push.
- Empty: out_valid=0. A pop request is ignored.
- Branch evaluation at push, result stored per entry:
  - NONE→0, EQ→equal, NE→~equal, LT→less, GE→~less, GT→greater, LE→~greater, ALWAYS→1.
- Flags are stored verbatim; no re-derivation.
- flush: count and pointers → 0 next cycle, out_valid=0. A push in the same cycle is discarded. flush has priority over push and pop. ovf_trap is unaffected.
- out_* data is stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro ALU_STAGE_OVF_TRAP_EN.
- When defined:
  - ovf_trap sets on push with in_flags.overflow=1 and in_wb_en=1.
  - It stays set until ovf_clear=1 (clear wins over a same-cycle set).
  - out_wb_en is suppressed for that entry.
- When undefined:
  - ovf_trap tied 0, ovf_clear ignored.
  - Overflow has no effect on out_wb_en.

Decomposition:
- Package alu_stage_pkg:
  - br_op_t enum (NONE=0, EQ=1, NE=2, LT=3, GE=4, GT=5, LE=6, ALWAYS=7).
  - alu_flags_t packed struct (the 6 flags in the order above).
  - Flag bit-index constants.
- Sub-module branch_eval: combinational br_op_t + alu_flags_t → taken. Instantiated once at the input.

Test Plan:
- Reset mid-stream: 2 entries buffered, pulse rst_n low → out_valid=0, in_ready=1, ovf_trap=0 immediately (async).
- Streaming: push result 0x1, 0x2, 0x3 on consecutive cycles, out_ready=1 → outputs 0x1, 0x2, 0x3 on cycles N+1..N+3, no bubbles.
- Backpressure: out_ready=0, push 3 entries → third push blocked (in_ready=0 after 2 pushes). Raise out_ready → entries drain in order, in_ready returns to 1.
- Branch: br_op=LT with less=1 → out_br_taken=1; br_op=GE with less=1 → 0; br_op=NE with equal=1 → 0; br_op=ALWAYS → 1.
- Flush with simultaneous push at count=1 → next cycle count=0, out_valid=0, pushed entry lost.
- With ALU_STAGE_OVF_TRAP_EN: push overflow=1, wb_en=1 → ovf_trap=1 next cycle, out_wb_en=0. ovf_clear with a simultaneous overflow push → ovf_trap=0.
